// File: rtl/ldst_ctrl_seq.sv
// Hardwired T-state sequencer for fetch plus ld/ldi/st/halt, with MEM_LAT-cycle memory steps.
// Optional macro SINGLE_STEP_EN adds a step_en input that gates every state and mc advance.
module ldst_ctrl_seq #(
  parameter int unsigned    OPW     = 5,
  parameter int unsigned    MEM_LAT = 1,
  parameter logic [OPW-1:0] OP_LD   = 5'b00000,
  parameter logic [OPW-1:0] OP_LDI  = 5'b00001,
  parameter logic [OPW-1:0] OP_ST   = 5'b00010,
  parameter logic [OPW-1:0] OP_HALT = 5'b11011
) (
  input  logic           Clock,
  input  logic           Reset,
  input  logic           run,
  input  logic [OPW-1:0] opcode,
`ifdef SINGLE_STEP_EN
  input  logic           step_en,
`endif
  output logic           PCout,
  output logic           MARin,
  output logic           IncPC,
  output logic           PCin,
  output logic           Read,
  output logic           Write,
  output logic           MDRin,
  output logic           MDRout,
  output logic           IRin,
  output logic           Yin,
  output logic           Zin,
  output logic           Zlowout,
  output logic           Cout,
  output logic           BAout,
  output logic           Gra,
  output logic           Grb,
  output logic           Rin,
  output logic           Rout,
  output logic           alu_add,
  output logic [3:0]     step,
  output logic           done,
  output logic           illegal,
  output logic           halted
);

  typedef enum logic [3:0] {
    S_IDLE = 4'd0, S_T0 = 4'd1, S_T1 = 4'd2, S_T2 = 4'd3, S_T3 = 4'd4,
    S_T4 = 4'd5, S_T5 = 4'd6, S_T6 = 4'd7, S_T7 = 4'd8, S_HALT = 4'd15
  } state_e;

  localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

  state_e         state_q, state_d, tgt_s;
  logic [3:0]     mc_q, mc_d;
  logic [OPW-1:0] op_q, op_d;
  logic           go_s, mem_step_s, mc_last_s, adv_s, op_legal_s;

`ifdef SINGLE_STEP_EN
  assign go_s = step_en;
`else
  assign go_s = 1'b1;
`endif

  assign mem_step_s = (state_q == S_T1) ||
                      ((state_q == S_T6) && (op_q == OP_LD)) ||
                      ((state_q == S_T7) && (op_q == OP_ST));
  assign mc_last_s  = (mc_q == LAT_M1);
  assign adv_s      = go_s && (!mem_step_s || mc_last_s);
  assign op_legal_s = (opcode == OP_LD) || (opcode == OP_LDI) || (opcode == OP_ST);

  // Next-state, memory-step counter and latched-opcode logic.
  always_comb begin
    tgt_s = S_IDLE;
    case (state_q)
      S_IDLE:  tgt_s = run ? S_T0 : S_IDLE;
      S_T0:    tgt_s = S_T1;
      S_T1:    tgt_s = S_T2;
      S_T2:    tgt_s = S_T3;
      S_T3: begin
        if (op_legal_s)              tgt_s = S_T4;
        else if (opcode == OP_HALT)  tgt_s = S_HALT;
        else                         tgt_s = run ? S_T0 : S_IDLE;
      end
      S_T4:    tgt_s = S_T5;
      S_T5:    tgt_s = (op_q == OP_LDI) ? (run ? S_T0 : S_IDLE) : S_T6;
      S_T6:    tgt_s = S_T7;
      S_T7:    tgt_s = run ? S_T0 : S_IDLE;
      S_HALT:  tgt_s = S_HALT;
      default: tgt_s = S_IDLE;
    endcase

    state_d = adv_s ? tgt_s : state_q;
    mc_d    = mc_q;
    if (!go_s)      mc_d = mc_q;
    else if (adv_s) mc_d = 4'd0;
    else            mc_d = mc_q + 4'd1;
    op_d = op_q;
    if (adv_s && (state_q == S_T3) && op_legal_s) op_d = opcode;
    else                                          op_d = op_q;
  end

  // State registers with synchronous reset.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= S_IDLE;
      mc_q    <= 4'd0;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      mc_q    <= mc_d;
      op_q    <= op_d;
    end
  end

  // Strobe decode: state and op_q, except T3 which looks at the live opcode.
  always_comb begin
    {PCout, MARin, IncPC, PCin, Read, Write, MDRin, MDRout, IRin, Yin, Zin,
     Zlowout, Cout, BAout, Gra, Grb, Rin, Rout, alu_add, done, illegal} = 21'd0;
    case (state_q)
      S_T0: {PCout, MARin, IncPC, PCin} = 4'b1111;
      S_T1: {Read, MDRin} = 2'b11;
      S_T2: {MDRout, IRin} = 2'b11;
      S_T3: begin
        if (op_legal_s)                  {Grb, BAout, Yin} = 3'b111;
        else if (opcode != OP_HALT)      illegal = 1'b1;
        else                             illegal = 1'b0;
      end
      S_T4: {Cout, alu_add, Zin} = 3'b111;
      S_T5: begin
        if (op_q == OP_LDI) {Zlowout, Gra, Rin, done} = 4'b1111;
        else                {Zlowout, MARin} = 2'b11;
      end
      S_T6: begin
        if (op_q == OP_LD)      {Read, MDRin} = 2'b11;
        else if (op_q == OP_ST) {Gra, Rout, MDRin} = 3'b111;
        else                    MDRin = 1'b0;
      end
      S_T7: begin
        if (op_q == OP_LD) begin
          {MDRout, Gra, Rin, done} = 4'b1111;
        end else if (op_q == OP_ST) begin
          Write = 1'b1;
          done  = mc_last_s;
        end else begin
          done = 1'b0;
        end
      end
      default: done = 1'b0;
    endcase
  end

  assign step   = state_q;
  assign halted = (state_q == S_HALT);

endmodule

// File: tb/tb_ldst_ctrl_seq.sv
// Directed bench for ldst_ctrl_seq: one instance with MEM_LAT=1, one with MEM_LAT=3.
module tb_ldst_ctrl_seq;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_HALT = 5'b11011;
  localparam logic [4:0] OP_BAD  = 5'b10101;

  // Bit positions in the observed strobe vector.
  localparam logic [21:0] M_PCOUT = 22'h000001, M_MARIN  = 22'h000002, M_INCPC = 22'h000004;
  localparam logic [21:0] M_PCIN  = 22'h000008, M_READ   = 22'h000010, M_WRITE = 22'h000020;
  localparam logic [21:0] M_MDRIN = 22'h000040, M_MDROUT = 22'h000080, M_IRIN  = 22'h000100;
  localparam logic [21:0] M_YIN   = 22'h000200, M_ZIN    = 22'h000400, M_ZLOW  = 22'h000800;
  localparam logic [21:0] M_COUT  = 22'h001000, M_BAOUT  = 22'h002000, M_GRA   = 22'h004000;
  localparam logic [21:0] M_GRB   = 22'h008000, M_RIN    = 22'h010000, M_ROUT  = 22'h020000;
  localparam logic [21:0] M_ADD   = 22'h040000, M_DONE   = 22'h080000, M_ILL   = 22'h100000;
  localparam logic [21:0] M_HALT  = 22'h200000;
  localparam logic [21:0] M_BUS   = M_PCOUT | M_MDROUT | M_ZLOW | M_ROUT | M_COUT | M_BAOUT;

  localparam logic [21:0] X_T0   = M_PCOUT | M_MARIN | M_INCPC | M_PCIN;
  localparam logic [21:0] X_RD   = M_READ | M_MDRIN;
  localparam logic [21:0] X_IR   = M_MDROUT | M_IRIN;
  localparam logic [21:0] X_T3   = M_GRB | M_BAOUT | M_YIN;
  localparam logic [21:0] X_T4   = M_COUT | M_ADD | M_ZIN;
  localparam logic [21:0] X_LDI5 = M_ZLOW | M_GRA | M_RIN | M_DONE;
  localparam logic [21:0] X_T5   = M_ZLOW | M_MARIN;
  localparam logic [21:0] X_LD7  = M_MDROUT | M_GRA | M_RIN | M_DONE;
  localparam logic [21:0] X_ST6  = M_GRA | M_ROUT | M_MDRIN;

  logic       clk = 1'b0;
  logic       rst1, run1, rst3, run3;
  logic [4:0] op1, op3;
  wire [21:0] s1, s3;
  wire [3:0]  st1, st3;
  int         tests = 0;
  int         fails = 0;

  always #5 clk = ~clk;

  ldst_ctrl_seq #(.MEM_LAT(1)) dut1 (
    .Clock(clk), .Reset(rst1), .run(run1), .opcode(op1),
`ifdef SINGLE_STEP_EN
    .step_en(1'b1),
`endif
    .PCout(s1[0]), .MARin(s1[1]), .IncPC(s1[2]), .PCin(s1[3]), .Read(s1[4]), .Write(s1[5]),
    .MDRin(s1[6]), .MDRout(s1[7]), .IRin(s1[8]), .Yin(s1[9]), .Zin(s1[10]), .Zlowout(s1[11]),
    .Cout(s1[12]), .BAout(s1[13]), .Gra(s1[14]), .Grb(s1[15]), .Rin(s1[16]), .Rout(s1[17]),
    .alu_add(s1[18]), .done(s1[19]), .illegal(s1[20]), .halted(s1[21]), .step(st1)
  );

  ldst_ctrl_seq #(.MEM_LAT(3)) dut3 (
    .Clock(clk), .Reset(rst3), .run(run3), .opcode(op3),
`ifdef SINGLE_STEP_EN
    .step_en(1'b1),
`endif
    .PCout(s3[0]), .MARin(s3[1]), .IncPC(s3[2]), .PCin(s3[3]), .Read(s3[4]), .Write(s3[5]),
    .MDRin(s3[6]), .MDRout(s3[7]), .IRin(s3[8]), .Yin(s3[9]), .Zin(s3[10]), .Zlowout(s3[11]),
    .Cout(s3[12]), .BAout(s3[13]), .Gra(s3[14]), .Grb(s3[15]), .Rin(s3[16]), .Rout(s3[17]),
    .alu_add(s3[18]), .done(s3[19]), .illegal(s3[20]), .halted(s3[21]), .step(st3)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input int sel, input string tag, input logic [3:0] est, input logic [21:0] em);
    logic [3:0]  ost;
    logic [21:0] om;
    ost = (sel == 1) ? st1 : st3;
    om  = (sel == 1) ? s1 : s3;
    tests++;
    assert (ost === est) else begin
      fails++;
      $error("FAIL %s step: observed %0d expected %0d", tag, ost, est);
    end
    tests++;
    assert (om === em) else begin
      fails++;
      $error("FAIL %s strobes: observed %06h expected %06h", tag, om, em);
    end
    tests++;
    assert (($countones(om & M_BUS) <= 1) && !(om[4] && om[5])) else begin
      fails++;
      $error("FAIL %s exclusion: observed %06h expected at most one bus driver, no Read+Write", tag, om);
    end
  endtask

  initial begin
    rst1 = 1'b1; rst3 = 1'b1; run1 = 1'b0; run3 = 1'b0; op1 = 5'd0; op3 = 5'd0;
    repeat (2) tick();
    rst1 = 1'b0; rst3 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick(); chk(1, "idle1", 4'd0, 22'd0); chk(3, "idle3", 4'd0, 22'd0);
    end

    // ldi with MEM_LAT=1; run drops during the second instruction
    run1 = 1'b1; op1 = OP_LDI;
    tick(); chk(1, "ldi_t0", 4'd1, X_T0);
    tick(); chk(1, "ldi_t1", 4'd2, X_RD);
    tick(); chk(1, "ldi_t2", 4'd3, X_IR);
    tick(); chk(1, "ldi_t3", 4'd4, X_T3);
    tick(); chk(1, "ldi_t4", 4'd5, X_T4);
    tick(); chk(1, "ldi_t5", 4'd6, X_LDI5);
    tick(); chk(1, "ldi_next", 4'd1, X_T0);
    run1 = 1'b0;
    tick(); chk(1, "ldi2_t1", 4'd2, X_RD);
    tick(); chk(1, "ldi2_t2", 4'd3, X_IR);
    tick(); chk(1, "ldi2_t3", 4'd4, X_T3);
    tick(); chk(1, "ldi2_t4", 4'd5, X_T4);
    tick(); chk(1, "ldi2_t5", 4'd6, X_LDI5);
    tick(); chk(1, "ldi2_idle", 4'd0, 22'd0);
    tick(); chk(1, "ldi2_hold", 4'd0, 22'd0);

    // ld with MEM_LAT=3
    run3 = 1'b1; op3 = OP_LD;
    tick(); chk(3, "ld_t0", 4'd1, X_T0);
    for (int i = 0; i < 3; i++) begin tick(); chk(3, "ld_t1", 4'd2, X_RD); end
    tick(); chk(3, "ld_t2", 4'd3, X_IR);
    tick(); chk(3, "ld_t3", 4'd4, X_T3);
    tick(); chk(3, "ld_t4", 4'd5, X_T4);
    tick(); chk(3, "ld_t5", 4'd6, X_T5);
    for (int i = 0; i < 3; i++) begin tick(); chk(3, "ld_t6", 4'd7, X_RD); end
    tick(); chk(3, "ld_t7", 4'd8, X_LD7);
    tick(); chk(3, "ld_next", 4'd1, X_T0);

    // st with MEM_LAT=3
    op3 = OP_ST;
    for (int i = 0; i < 3; i++) begin tick(); chk(3, "st_t1", 4'd2, X_RD); end
    tick(); chk(3, "st_t2", 4'd3, X_IR);
    tick(); chk(3, "st_t3", 4'd4, X_T3);
    tick(); chk(3, "st_t4", 4'd5, X_T4);
    tick(); chk(3, "st_t5", 4'd6, X_T5);
    tick(); chk(3, "st_t6", 4'd7, X_ST6);
    tick(); chk(3, "st_t7a", 4'd8, M_WRITE);
    tick(); chk(3, "st_t7b", 4'd8, M_WRITE);
    tick(); chk(3, "st_t7c", 4'd8, M_WRITE | M_DONE);
    tick(); chk(3, "st_next", 4'd1, X_T0);

    // unsupported opcode, then halt
    op3 = OP_BAD;
    for (int i = 0; i < 3; i++) begin tick(); chk(3, "ill_t1", 4'd2, X_RD); end
    tick(); chk(3, "ill_t2", 4'd3, X_IR);
    tick(); chk(3, "ill_t3", 4'd4, M_ILL);
    tick(); chk(3, "ill_next", 4'd1, X_T0);
    op3 = OP_HALT;
    for (int i = 0; i < 3; i++) begin tick(); chk(3, "hlt_t1", 4'd2, X_RD); end
    tick(); chk(3, "hlt_t2", 4'd3, X_IR);
    tick(); chk(3, "hlt_t3", 4'd4, 22'd0);
    for (int i = 0; i < 20; i++) begin tick(); chk(3, "halt", 4'd15, M_HALT); end
    rst3 = 1'b1; run3 = 1'b0;
    tick(); chk(3, "halt_rst", 4'd0, 22'd0);
    rst3 = 1'b0;
    tick(); chk(3, "post_rst", 4'd0, 22'd0);

    // reset during the second Read cycle of ld's T6
    run3 = 1'b1; op3 = OP_LD;
    tick(); chk(3, "ldr_t0", 4'd1, X_T0);
    for (int i = 0; i < 3; i++) begin tick(); chk(3, "ldr_t1", 4'd2, X_RD); end
    tick(); chk(3, "ldr_t2", 4'd3, X_IR);
    tick(); chk(3, "ldr_t3", 4'd4, X_T3);
    tick(); chk(3, "ldr_t4", 4'd5, X_T4);
    tick(); chk(3, "ldr_t5", 4'd6, X_T5);
    tick(); chk(3, "ldr_t6a", 4'd7, X_RD);
    tick(); chk(3, "ldr_t6b", 4'd7, X_RD);
    rst3 = 1'b1; run3 = 1'b0;
    tick(); chk(3, "ldr_rst", 4'd0, 22'd0);
    rst3 = 1'b0;
    for (int i = 0; i < 3; i++) begin tick(); chk(3, "ldr_idle", 4'd0, 22'd0); end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ldst_ctrl_seq.md
Name: ldst_ctrl_seq

Overview:
- Hardwired control-step sequencer that drives datapath control strobes for instruction fetch and the load/store-immediate family (ld, ldi, st, halt).
- Replaces hand-sequenced T-state stimulus with a synthesizable Moore/Mealy FSM.
- Memory-latency is parametrised, so Read/Write strobes stretch over multiple cycles.
- Sits beside the datapath and drives its control inputs directly; the opcode input is fed back from IR[31:27].

Parameters:
- OPW, 5, opcode width.
- MEM_LAT, 1, cycles Read/Write stay asserted per memory step (legal range 1..15).
- OP_LD, 5'b00000, ld opcode.
- OP_LDI, 5'b00001, ldi opcode.
- OP_ST, 5'b00010, st opcode.
- OP_HALT, 5'b11011, halt opcode.

Ports:
- Clock  in  1  system clock, rising edge.
- Reset  in  1  synchronous, active-high.
- run  in  1  level; high permits leaving IDLE and starting the next fetch.
- opcode  in  OPW  IR[31:27]; valid from the T3 cycle onward.
- PCout, MARin, IncPC, PCin, Read, Write, MDRin, MDRout, IRin, Yin, Zin, Zlowout, Cout, BAout, Gra, Grb, Rin, Rout  out  1 each  datapath controls.
- alu_add  out  1  ALU operation = ADD (high with Zin).
- step  out  4  current T-state encoding: IDLE=0, T0..T7=1..8, HALT=15.
- done  out  1  one-cycle pulse in the last step of each instruction.
- illegal  out  1  one-cycle pulse in T3 when the opcode is unsupported.
- halted  out  1  high while in HALT.

Behaviour:
- Reset (synchronous, active-high): state=IDLE, mem counter=0, op_q=0. All outputs are 0 in IDLE.
- One T-state per clock except memory steps, which last MEM_LAT cycles. A counter mc counts 0..MEM_LAT-1; the state advances when mc==MEM_LAT-1, and mc clears on every state change.
- Outputs:
  - Moore decode of state and op_q, except T3, which decodes the live opcode.
  - Each strobe is high for the entire cycle(s) of its step.
- IDLE: advance to T0 if run=1, else hold.
- Fetch:
  - T0: PCout, MARin, IncPC, PCin (PC+1 latched at end of cycle).
  - T1: Read, MDRin for MEM_LAT cycles.
  - T2: MDRout, IRin.
- T3 (live opcode):
  - ld/ldi/st: Grb, BAout, Yin. op_q<=opcode at exit.
  - halt: no strobes; next state HALT.
  - other: illegal=1, no strobes; next state T0 if run, else IDLE.
- ldi:
  - T4: Cout, alu_add, Zin.
  - T5: Zlowout, Gra, Rin, done.
- ld:
  - T4: Cout, alu_add, Zin.
  - T5: Zlowout, MARin.
  - T6: Read, MDRin (MEM_LAT cycles).
  - T7: MDRout, Gra, Rin, done.
- st:
  - T4: Cout, alu_add, Zin.
  - T5: Zlowout, MARin.
  - T6: Gra, Rout, MDRin.
  - T7: Write (MEM_LAT cycles), done in its final cycle.
- After the done step: T0 if run=1, else IDLE. run is sampled only in IDLE and at instruction boundaries; deasserting run mid-instruction has no effect until the boundary.
- HALT: all strobes 0, halted=1, sticky until Reset.
- Reset mid-instruction (including mid-Read/Write): next cycle is IDLE with all strobes 0; the partial instruction is abandoned.
- Mutual exclusion invariants:
  - At most one of {PCout, MDRout, Zlowout, Rout, Cout, BAout} is driving the bus in any cycle.
  - Read and Write are never high together.
- Cycle counts per instruction, including fetch:
  - ldi: 5+MEM_LAT.
  - ld: 6+2*MEM_LAT.
  - st: 6+2*MEM_LAT.

Optional Feature:
- Macro SINGLE_STEP_EN.
- When defined: adds input step_en (1 bit).
  - Every state transition and mc increment additionally requires step_en=1; otherwise state and mc hold and the current strobes stay asserted.
  - Reset still overrides.
- When undefined: the port does not exist and the sequencer free-runs as above.

Test Plan:
- Reset=1 for 2 cycles, then run=0 for 5 cycles -> step=0 and all strobes 0 throughout.
- MEM_LAT=1, run=1, opcode=OP_LDI -> step sequence 1,2,3,4,5,6. Control checks:
  - Read high for exactly 1 cycle (step=2).
  - Gra/Rin/Zlowout/done high only at step=6.
  - Next cycle step=1.
- MEM_LAT=3, opcode=OP_LD -> 12 cycles per instruction:
  - Read high 3 consecutive cycles at step=2 and again 3 at step=7.
  - done at step=8.
- MEM_LAT=3, opcode=OP_ST -> Write high 3 cycles at step=8, never together with Read. Rout and MDRin high at step=7; done in the last Write cycle.
- opcode=5'b10101 -> illegal pulses once at step=4 with no strobes that cycle. Then opcode=OP_HALT -> step=15 and halted=1, held 20 cycles until Reset returns step=0.
- Reset asserted during the 2nd Read cycle of T6 (MEM_LAT=3) -> next cycle step=0, Read=0, done never pulses.
